// File: rtl/psum_su_adder_pkg.sv
// psum_su_adder_pkg: FSM state encoding and shared width defaults for the spatial-unit psum adder.
package psum_su_adder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
  localparam int ACC_BITWIDTH_DEF = 24;
endpackage

// File: rtl/psum_su_adder_column.sv
// su_column_adder: sign-extends and reduces one PE column of psums, optionally adding the stored lane sum, into a registered result.
module su_column_adder #(
  parameter int ROW          = 16,
  parameter int OUT_BITWIDTH = 16,
  parameter int ACC_BITWIDTH = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_load,
  input  logic                        i_accum,
  input  logic [ROW*OUT_BITWIDTH-1:0] i_psum,
  input  logic [ACC_BITWIDTH-1:0]     i_acc,
  output logic [ACC_BITWIDTH-1:0]     o_sum
);
  logic [ACC_BITWIDTH-1:0] w_sum;
  logic [ACC_BITWIDTH-1:0] r_sum;
  always_comb begin
    w_sum = i_accum ? i_acc : '0;
    for (int r = 0; r < ROW; r++)
      w_sum = w_sum + {{(ACC_BITWIDTH-OUT_BITWIDTH){i_psum[r*OUT_BITWIDTH+OUT_BITWIDTH-1]}},
                       i_psum[r*OUT_BITWIDTH +: OUT_BITWIDTH]};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sum <= '0;
    else if (i_load) r_sum <= w_sum;
  assign o_sum = r_sum;
endmodule

// File: rtl/psum_su_adder.sv
// psum_su_adder: reads a PE psum tile address by address, reduces each column and accumulates into per-lane sums.
// Define PSUM_SU_ADDER_RELU_EN to clamp negative output lanes to zero (stored sums stay unclamped).
module psum_su_adder
  import psum_su_adder_pkg::*;
#(
  parameter int ROW                = 16,
  parameter int COL                = 16,
  parameter int OUT_BITWIDTH       = 16,
  parameter int PSUM_ADDR_BITWIDTH = 2,
  parameter int PSUM_DEPTH         = 2**PSUM_ADDR_BITWIDTH,
  parameter int ACC_BITWIDTH       = ACC_BITWIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pe_psum_finish,
  input  logic                              turn_off,
  input  logic                              accum_en,
  input  logic [OUT_BITWIDTH*ROW*COL-1:0]   psum_out,
  output logic [PSUM_ADDR_BITWIDTH-1:0]     addr_from_su_adder,
  output logic                              su_add_finish,
  output logic                              out_valid,
  output logic [PSUM_ADDR_BITWIDTH-1:0]     out_addr,
  output logic [ACC_BITWIDTH*COL-1:0]       out_data
);
  localparam logic [PSUM_ADDR_BITWIDTH-1:0] LAST = PSUM_ADDR_BITWIDTH'(PSUM_DEPTH-1);
  state_t                        r_state;
  logic [PSUM_ADDR_BITWIDTH-1:0] r_addr;
  logic                          r_accum;
  logic                          r_finish;
  logic                          r_p1_valid;
  logic [PSUM_ADDR_BITWIDTH-1:0] r_p1_addr;
  logic                          r_out_valid;
  logic [PSUM_ADDR_BITWIDTH-1:0] r_out_addr;
  logic [ACC_BITWIDTH-1:0]       r_acc [PSUM_DEPTH][COL];
  logic [ACC_BITWIDTH-1:0]       w_lane [COL];
  logic [ROW*OUT_BITWIDTH-1:0]   w_col [COL];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_accum  <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (pe_psum_finish) begin
            r_state <= S_READ;
            r_accum <= accum_en;
            r_addr  <= '0;
          end
        S_READ: begin
          r_addr <= r_addr + 1'b1;
          if (r_addr == LAST) begin
            r_state <= S_DRAIN;
            r_addr  <= '0;
          end
        end
        S_DRAIN:
          if (r_out_valid && r_out_addr == LAST) begin
            r_state  <= S_DONE;
            r_finish <= 1'b1;
          end
        S_DONE:
          if (turn_off) begin
            r_state  <= S_IDLE;
            r_finish <= 1'b0;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  // RF data for the address driven last cycle arrives now; the column adders register it.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_p1_valid  <= 1'b0;
      r_p1_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
    end else begin
      r_p1_valid  <= r_state == S_READ;
      r_p1_addr   <= r_addr;
      r_out_valid <= r_p1_valid;
      r_out_addr  <= r_p1_addr;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int a = 0; a < PSUM_DEPTH; a++)
        for (int c = 0; c < COL; c++)
          r_acc[a][c] <= '0;
    end else if (r_out_valid) begin
      for (int c = 0; c < COL; c++)
        r_acc[r_out_addr][c] <= w_lane[c];
    end
  for (genvar c = 0; c < COL; c++) begin : g_col
    for (genvar r = 0; r < ROW; r++) begin : g_row
      assign w_col[c][r*OUT_BITWIDTH +: OUT_BITWIDTH] = psum_out[(r*COL+c)*OUT_BITWIDTH +: OUT_BITWIDTH];
    end
    su_column_adder #(
      .ROW(ROW), .OUT_BITWIDTH(OUT_BITWIDTH), .ACC_BITWIDTH(ACC_BITWIDTH)
    ) u_col (
      .clk(clk),
      .reset(reset),
      .i_load(r_p1_valid),
      .i_accum(r_accum),
      .i_psum(w_col[c]),
      .i_acc(r_acc[r_p1_addr][c]),
      .o_sum(w_lane[c])
    );
`ifdef PSUM_SU_ADDER_RELU_EN
    assign out_data[c*ACC_BITWIDTH +: ACC_BITWIDTH] = w_lane[c][ACC_BITWIDTH-1] ? '0 : w_lane[c];
`else
    assign out_data[c*ACC_BITWIDTH +: ACC_BITWIDTH] = w_lane[c];
`endif
  end
  assign addr_from_su_adder = r_addr;
  assign su_add_finish      = r_finish;
  assign out_valid          = r_out_valid;
  assign out_addr           = r_out_addr;
endmodule

// File: tb/tb_psum_su_adder.sv
// tb_psum_su_adder: randomized and directed jobs checked against a lane-sum reference model.
module tb_psum_su_adder;
  localparam int ROW = 16, COL = 16, OB = 16, AB = 2, DEPTH = 4, ACC = 24;
`ifdef PSUM_SU_ADDER_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif
  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  pe_psum_finish = 1'b0;
  logic                  turn_off = 1'b0;
  logic                  accum_en = 1'b0;
  logic [OB*ROW*COL-1:0] psum_out;
  logic [AB-1:0]         addr_from_su_adder;
  logic                  su_add_finish;
  logic                  out_valid;
  logic [AB-1:0]         out_addr;
  logic [ACC*COL-1:0]    out_data;
  logic [OB*ROW*COL-1:0] rf [DEPTH];
  logic [AB-1:0]         rd_addr = '0;
  int                    pe [DEPTH][ROW][COL];
  logic signed [ACC-1:0] acc_m [DEPTH][COL];
  logic signed [ACC-1:0] nxt_m [DEPTH][COL];
  logic [ACC*COL-1:0]    exp_out [DEPTH];
  int                    errors = 0;
  int                    checks = 0;

  psum_su_adder dut (
    .clk(clk), .reset(reset), .pe_psum_finish(pe_psum_finish), .turn_off(turn_off),
    .accum_en(accum_en), .psum_out(psum_out), .addr_from_su_adder(addr_from_su_adder),
    .su_add_finish(su_add_finish), .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_addr <= addr_from_su_adder;
  assign psum_out = rf[rd_addr];

  task automatic chk(input string tag, input logic [ACC*COL-1:0] obs, input logic [ACC*COL-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input int mode);
    for (int a = 0; a < DEPTH; a++)
      for (int r = 0; r < ROW; r++)
        for (int c = 0; c < COL; c++) begin
          pe[a][r][c] = mode == 0 ? 1 : mode == 1 ? (r == 0 ? -5 : 0) : mode == 2 ? 32767
                      : int'($urandom_range(0, 65535)) - 32768;
          rf[a][(r*COL+c)*OB +: OB] = 16'(pe[a][r][c]);
        end
  endtask

  task automatic model(input bit acc_en);
    for (int a = 0; a < DEPTH; a++)
      for (int c = 0; c < COL; c++) begin
        int s;
        s = acc_en ? int'(acc_m[a][c]) : 0;
        for (int r = 0; r < ROW; r++) s += pe[a][r][c];
        nxt_m[a][c] = ACC'(s);
        exp_out[a][c*ACC +: ACC] = (RELU && nxt_m[a][c] < 0) ? '0 : nxt_m[a][c];
      end
  endtask

  task automatic run_job(input bit acc_en, input bit toff_early, input bit fin_in_flight);
    model(acc_en);
    @(negedge clk);
    accum_en = acc_en;
    pe_psum_finish = 1'b1;
    @(negedge clk);
    pe_psum_finish = 1'b0;
    accum_en = ~acc_en;
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("addr_c%0d", i), addr_from_su_adder, (i <= 4) ? i - 1 : 0);
      chk($sformatf("valid_c%0d", i), out_valid, (i >= 3 && i <= 6));
      if (i >= 3 && i <= 6) begin
        chk($sformatf("out_addr_c%0d", i), out_addr, i - 3);
        chk($sformatf("out_data_a%0d", i - 3), out_data, exp_out[i-3]);
      end
      chk($sformatf("finish_c%0d", i), su_add_finish, i == 7);
      turn_off = toff_early && i <= 5;
      pe_psum_finish = fin_in_flight && i == 2;
      @(negedge clk);
    end
    for (int j = 0; j < 10; j++) begin
      chk("done_hold_finish", su_add_finish, 1'b1);
      chk("done_hold_valid", out_valid, 1'b0);
      chk("done_hold_addr", addr_from_su_adder, 0);
      pe_psum_finish = j == 3;
      @(negedge clk);
    end
    turn_off = 1'b1;
    @(negedge clk);
    turn_off = 1'b0;
    chk("finish_release", su_add_finish, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_addr", addr_from_su_adder, 0);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_finish", su_add_finish, 1'b0);
    end
    acc_m = nxt_m;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_finish"}, su_add_finish, 1'b0);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_rd_addr"}, addr_from_su_adder, 0);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++)
      for (int c = 0; c < COL; c++) acc_m[a][c] = '0;
    fill(0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    run_job(1'b0, 1'b0, 1'b0);
    run_job(1'b1, 1'b0, 1'b0);
    run_job(1'b0, 1'b1, 1'b1);
    fill(1);
    run_job(1'b0, 1'b0, 1'b0);
    fill(2);
    run_job(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      fill(3);
      run_job(n > 0 ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    fill(3);
    model(1'b1);
    @(negedge clk);
    accum_en = 1'b1;
    pe_psum_finish = 1'b1;
    @(negedge clk);
    pe_psum_finish = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_2nd_valid", out_valid, 1'b1);
    chk("abort_2nd_addr", out_addr, 1);
    chk("abort_2nd_data", out_data, exp_out[1]);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < DEPTH; a++)
      for (int c = 0; c < COL; c++) acc_m[a][c] = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_all_zero("post_abort");
    end
    fill(0);
    run_job(1'b1, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_su_adder.md
PSUM_SU_ADDER -- requirements
Module: psum_su_adder

Interface
REQ-001 SHALL have parameter ROW, default 16, PE array rows reduced per column.
REQ-002 SHALL have parameter COL, default 16, PE array columns; one output lane each.
REQ-003 SHALL have parameter OUT_BITWIDTH, default 16, signed psum width per PE.
REQ-004 SHALL have parameter PSUM_ADDR_BITWIDTH, default 2, and PSUM_DEPTH, default 4, equal to 2^PSUM_ADDR_BITWIDTH.
REQ-005 SHALL have parameter ACC_BITWIDTH, default 24, signed accumulator/output width per lane.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have port pe_psum_finish, input, 1: pulse marking that the PE psum RFs hold a complete tile.
REQ-009 SHALL have port turn_off, input, 1: acknowledge that releases su_add_finish.
REQ-010 SHALL have port accum_en, input, 1: add to the stored lane sums (1) or overwrite them (0); sampled at job start.
REQ-011 SHALL have port psum_out, input, OUT_BITWIDTH*ROW*COL: PE psums; PE (r,c) at slice index r*COL+c.
REQ-012 SHALL have port addr_from_su_adder, output, PSUM_ADDR_BITWIDTH: PE psum RF read address.
REQ-013 SHALL have port su_add_finish, output, 1: job complete, held until turn_off.
REQ-014 SHALL have ports out_valid (1), out_addr (PSUM_ADDR_BITWIDTH), out_data (ACC_BITWIDTH*COL), all outputs: result write toward the output GBF.

Function
REQ-015 SHALL implement FSM IDLE, READ, DRAIN, DONE.
REQ-016 IDLE->READ on pe_psum_finish=1; accum_en latched; addr_from_su_adder=0 in the first READ cycle.
REQ-017 In READ, addr_from_su_adder SHALL increment by 1 per cycle; after PSUM_DEPTH-1 is driven, the next state is DRAIN.
REQ-018 psum_out SHALL be treated as valid one cycle after its address (one-cycle RF read) and registered at that point.
REQ-019 Per column c, SHALL sign-extend the ROW psums to ACC_BITWIDTH and sum them in a registered stage, wrapping modulo 2^ACC_BITWIDTH.
REQ-020 Lane result SHALL be row-sum + acc[addr][c] when the latched accum_en=1, else row-sum; the result is written back to acc[addr][c].
REQ-021 out_valid SHALL assert exactly 2 cycles after address a is driven, with out_addr=a and out_data carrying the lane results (lane c at slice c).
REQ-022 out_valid SHALL be high for exactly PSUM_DEPTH consecutive cycles per job, with addresses ascending.
REQ-023 DRAIN SHALL last until the last out_valid, then go to DONE; su_add_finish=1 throughout DONE.
REQ-024 DONE->IDLE on turn_off=1; su_add_finish SHALL drop the cycle after turn_off is sampled high.
REQ-025 pe_psum_finish outside IDLE SHALL be ignored, with no effect on the job in flight.
REQ-026 turn_off outside DONE SHALL be ignored.
REQ-027 Outside READ, addr_from_su_adder SHALL hold 0.

Reset
REQ-028 reset=0 SHALL immediately force IDLE and set every output to 0: su_add_finish, out_valid, out_addr, out_data and addr_from_su_adder.
REQ-029 reset SHALL clear all acc entries, pipeline registers and the latched accum_en.
REQ-030 A mid-job reset SHALL abort the job with no further out_valid; a job starts only on a new pe_psum_finish after release.

Configuration
REQ-031 With macro PSUM_SU_ADDER_RELU_EN defined, negative out_data lanes SHALL be driven as 0 while acc stores the unclamped value.
REQ-032 Without PSUM_SU_ADDER_RELU_EN, out_data SHALL equal the stored signed sum.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding and the default ACC_BITWIDTH constant.
REQ-034 The per-column reduction SHALL be one sub-module, su_column_adder, instantiated COL times.

Verification
REQ-035 Every PE=1, accum_en=0, one job -> 4 out_valid cycles, addr 0..3, every lane =16, then su_add_finish.
REQ-036 Repeat REQ-035 with accum_en=1 -> every lane =32; with accum_en=0 again -> every lane =16.
REQ-037 Row 0 =-5, other rows 0, with and without PSUM_SU_ADDER_RELU_EN -> lanes 0 and -5 respectively.
REQ-038 Every PE=0x7FFF -> every lane =524272 (16*32767), no wrap.
REQ-039 Hold turn_off=0 for 10 cycles in DONE -> su_add_finish stays 1; turn_off=1 -> low the next cycle; a pe_psum_finish during DONE is ignored.
REQ-040 reset pulse after the 2nd out_valid -> all outputs 0 immediately, no further out_valid, acc cleared.
